// File: rtl/brownout_dig_mc.sv
// Brownout supervisor digital controller: per-channel trip decode, comparator
// synchroniser/debounce, blanking/assert/hold FSM, sticky status and IRQ.
module brownout_dig_mc #(
    parameter int NCH        = 2,
    parameter int TRIP_W     = 3,
    parameter int DEB_CNT    = 4,
    parameter int HOLD_LONG  = 4096,
    parameter int HOLD_SHORT = 16,
    parameter int STARTUP    = 8
) (
    input  logic                          osc_ck,
    input  logic                          rst_n,
    input  logic [NCH-1:0]                ena,
    input  logic [NCH*TRIP_W-1:0]         trip,
    input  logic [NCH-1:0]                brout_filt,
    input  logic                          force_rc_osc,
    input  logic                          force_short_oneshot,
    input  logic [NCH-1:0]                clr,
    output logic [NCH*(2**TRIP_W)-1:0]    trip_decoded,
    output logic [NCH-1:0]                out,
    output logic [NCH-1:0]                timed_out,
    output logic [NCH-1:0]                sticky,
    output logic                          irq,
    output logic                          osc_ena
);

    localparam int DW   = 2 ** TRIP_W;
    localparam int MAX1 = (HOLD_LONG > HOLD_SHORT) ? HOLD_LONG : HOLD_SHORT;
    localparam int MAX2 = (STARTUP > DEB_CNT) ? STARTUP : DEB_CNT;
    localparam int MAXC = (MAX1 > MAX2) ? MAX1 : MAX2;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_MONITOR = 3'd2;
    localparam logic [2:0] S_ASSERT  = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_DEB      = CW'(DEB_CNT);
    localparam logic [CW-1:0] C_SET_LAST = CW'(STARTUP - 1);
    localparam logic [CW-1:0] C_LONG     = CW'(HOLD_LONG);
    localparam logic [CW-1:0] C_SHORT    = CW'(HOLD_SHORT);
    localparam logic [DW-1:0] C_TAP0     = {{(DW-1){1'b0}}, 1'b1};

    logic [NCH-1:0]    r_sync1, r_sync2;
    logic [2:0]        r_state     [NCH];
    logic [2:0]        w_state_nxt [NCH];
    logic [CW-1:0]     r_cnt       [NCH];
    logic [CW-1:0]     w_cnt_nxt   [NCH];
    logic [TRIP_W-1:0] r_trip_prev [NCH];
    logic [NCH*DW-1:0] r_trip_dec, w_trip_dec;
    logic [NCH-1:0]    r_out, w_out_nxt, r_to, w_to_nxt, r_sticky, w_set;
    logic              r_irq, r_osc_ena;

    // One shared counter per channel: blanking, debounce and hold never overlap.
    always_comb begin
        w_trip_dec = '0;
        w_out_nxt  = '0;
        w_to_nxt   = '0;
        w_set      = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_trip_dec[i*DW +: DW] = C_TAP0 << trip[i*TRIP_W +: TRIP_W];
            if (!ena[i]) begin
                w_state_nxt[i] = S_OFF;
                w_cnt_nxt[i]   = '0;
            end else begin
                case (r_state[i])
                    S_OFF: begin
                        w_state_nxt[i] = S_SETTLE;
                        w_cnt_nxt[i]   = '0;
                    end
                    S_SETTLE: begin
                        if (r_cnt[i] == C_SET_LAST) begin
                            w_state_nxt[i] = S_MONITOR;
                            w_cnt_nxt[i]   = '0;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + C_ONE;
                        end
                    end
                    S_MONITOR: begin
                        if (r_cnt[i] == C_DEB) begin
                            w_state_nxt[i] = S_ASSERT;
                            w_cnt_nxt[i]   = '0;
                            w_set[i]       = 1'b1;
                        end else if (!r_sync2[i] ||
                                     (trip[i*TRIP_W +: TRIP_W] != r_trip_prev[i])) begin
                            w_cnt_nxt[i] = '0;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + C_ONE;
                        end
                    end
                    S_ASSERT: begin
                        if (!r_sync2[i]) begin
                            w_state_nxt[i] = S_HOLD;
                            w_cnt_nxt[i]   = force_short_oneshot ? C_SHORT : C_LONG;
                        end
                    end
                    S_HOLD: begin
                        if (r_sync2[i]) begin
                            w_state_nxt[i] = S_ASSERT;
                            w_cnt_nxt[i]   = '0;
                        end else if (r_cnt[i] == C_ONE) begin
                            w_state_nxt[i] = S_MONITOR;
                            w_cnt_nxt[i]   = '0;
                            w_to_nxt[i]    = 1'b1;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] - C_ONE;
                        end
                    end
                    default: begin
                        w_state_nxt[i] = S_OFF;
                        w_cnt_nxt[i]   = '0;
                    end
                endcase
            end
            w_out_nxt[i] = (w_state_nxt[i] == S_ASSERT) || (w_state_nxt[i] == S_HOLD);
        end
    end

    always_ff @(posedge osc_ck or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_out     <= '0;
            r_to      <= '0;
            r_sticky  <= '0;
            r_irq     <= 1'b0;
            r_osc_ena <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                r_state[i]             <= S_OFF;
                r_cnt[i]               <= '0;
                r_trip_prev[i]         <= '0;
                r_trip_dec[i*DW +: DW] <= C_TAP0;
            end
        end else begin
            r_sync1    <= brout_filt;
            r_sync2    <= r_sync1;
            r_trip_dec <= w_trip_dec;
            r_out      <= w_out_nxt;
            r_to       <= w_to_nxt;
            // A new event in the same cycle as a clear keeps the flag set.
            r_sticky   <= w_set | (r_sticky & ~clr);
            r_irq      <= |r_sticky;
            r_osc_ena  <= force_rc_osc | (|ena);
            for (int unsigned i = 0; i < NCH; i++) begin
                r_state[i]     <= w_state_nxt[i];
                r_cnt[i]       <= w_cnt_nxt[i];
                r_trip_prev[i] <= trip[i*TRIP_W +: TRIP_W];
            end
        end
    end

    assign trip_decoded = r_trip_dec;
    assign out          = r_out;
    assign timed_out    = r_to;
    assign sticky       = r_sticky;
    assign irq          = r_irq;
    assign osc_ena      = r_osc_ena;

endmodule

// File: tb/tb_brownout_dig_mc.sv
// Scoreboard bench for brownout_dig_mc: directed scenarios plus random traffic,
// expectations from a cycle-level behavioural model queued ahead of each edge.
module tb_brownout_dig_mc;

    localparam int NCH        = 2;
    localparam int TRIP_W     = 3;
    localparam int DEB_CNT    = 4;
    localparam int HOLD_LONG  = 4096;
    localparam int HOLD_SHORT = 16;
    localparam int STARTUP    = 8;
    localparam int DW         = 2 ** TRIP_W;

    logic                  osc_ck;
    logic                  rst_n;
    logic [NCH-1:0]        ena;
    logic [NCH*TRIP_W-1:0] trip;
    logic [NCH-1:0]        brout_filt;
    logic                  force_rc_osc;
    logic                  force_short_oneshot;
    logic [NCH-1:0]        clr;
    logic [NCH*DW-1:0]     trip_decoded;
    logic [NCH-1:0]        out;
    logic [NCH-1:0]        timed_out;
    logic [NCH-1:0]        sticky;
    logic                  irq;
    logic                  osc_ena;

    brownout_dig_mc #(
        .NCH(NCH), .TRIP_W(TRIP_W), .DEB_CNT(DEB_CNT),
        .HOLD_LONG(HOLD_LONG), .HOLD_SHORT(HOLD_SHORT), .STARTUP(STARTUP)
    ) dut (
        .osc_ck(osc_ck), .rst_n(rst_n), .ena(ena), .trip(trip),
        .brout_filt(brout_filt), .force_rc_osc(force_rc_osc),
        .force_short_oneshot(force_short_oneshot), .clr(clr),
        .trip_decoded(trip_decoded), .out(out), .timed_out(timed_out),
        .sticky(sticky), .irq(irq), .osc_ena(osc_ena)
    );

    typedef struct {
        logic [NCH*DW-1:0] td;
        logic [NCH-1:0]    o;
        logic [NCH-1:0]    to;
        logic [NCH-1:0]    st;
        logic              irq;
        logic              osc;
    } exp_t;

    exp_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    bit   started = 0;
    event ev_async;

    // Behavioural model: age since enable, debounce run length, hold time left.
    bit                m_p1 [NCH];
    bit                m_p2 [NCH];
    int                m_age[NCH];
    int                m_run[NCH];
    int                m_hold[NCH];
    bit                m_asserted[NCH];
    bit                m_sticky[NCH];
    logic [TRIP_W-1:0] m_last_trip[NCH];

    initial begin
        osc_ck = 1'b0;
        forever #5 osc_ck = ~osc_ck;
    end

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_p1[c] = 0; m_p2[c] = 0; m_age[c] = 0; m_run[c] = 0;
            m_hold[c] = 0; m_asserted[c] = 0; m_sticky[c] = 0;
            m_last_trip[c] = '0;
        end
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        logic [DW-1:0] one = 1;
        e.td = '0;
        for (int c = 0; c < NCH; c++) e.td[c*DW +: DW] = one;
        e.o = '0; e.to = '0; e.st = '0; e.irq = 1'b0; e.osc = 1'b0;
        return e;
    endfunction

    function automatic void model_step();
        exp_t          e;
        bit            any_st = 0;
        bit            s, chg, set, to;
        logic [TRIP_W-1:0] tr;
        logic [DW-1:0] one = 1;
        if (!rst_n) begin
            model_reset();
            q.push_back(reset_exp());
            return;
        end
        for (int c = 0; c < NCH; c++) any_st |= m_sticky[c];
        e.irq = any_st;
        e.osc = force_rc_osc | (|ena);
        e.td = '0; e.o = '0; e.to = '0; e.st = '0;
        for (int c = 0; c < NCH; c++) begin
            s = m_p2[c];
            m_p2[c] = m_p1[c];
            m_p1[c] = brout_filt[c];
            tr = trip[c*TRIP_W +: TRIP_W];
            chg = (tr != m_last_trip[c]);
            m_last_trip[c] = tr;
            set = 0; to = 0;
            if (!ena[c]) begin
                m_age[c] = 0; m_run[c] = 0; m_hold[c] = 0; m_asserted[c] = 0;
            end else if (m_age[c] <= STARTUP) begin
                m_age[c]++;
            end else if (!m_asserted[c]) begin
                if (m_run[c] == DEB_CNT) begin
                    m_asserted[c] = 1; set = 1; m_run[c] = 0;
                end else if (chg || !s) m_run[c] = 0;
                else m_run[c]++;
            end else if (m_hold[c] == 0) begin
                if (!s) m_hold[c] = force_short_oneshot ? HOLD_SHORT : HOLD_LONG;
            end else if (s) begin
                m_hold[c] = 0;
            end else if (m_hold[c] == 1) begin
                m_hold[c] = 0; m_asserted[c] = 0; to = 1;
            end else begin
                m_hold[c]--;
            end
            m_sticky[c] = set | (m_sticky[c] & !clr[c]);
            e.o[c]  = m_asserted[c];
            e.to[c] = to;
            e.st[c] = m_sticky[c];
            e.td[c*DW +: DW] = one << tr;
        end
        q.push_back(e);
    endfunction

    // Called at a negedge with inputs settled; returns at the following negedge.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            started = 1;
            @(posedge osc_ck);
            @(negedge osc_ck);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge osc_ck or ev_async);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("trip_decoded", 64'(trip_decoded), 64'(e.td));
                chk("out",          64'(out),          64'(e.o));
                chk("timed_out",    64'(timed_out),    64'(e.to));
                chk("sticky",       64'(sticky),       64'(e.st));
                chk("irq",          64'(irq),          64'(e.irq));
                chk("osc_ena",      64'(osc_ena),      64'(e.osc));
            end else if (started) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog at %0t: got timeout expected completion", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        rst_n = 1'b0; ena = '0; trip = '0; brout_filt = '0;
        force_rc_osc = 1'b0; force_short_oneshot = 1'b0; clr = '0;
        model_reset();
        @(negedge osc_ck);
        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        // Enable ch0 with distinct trip codes, blank through STARTUP
        ena = 2'b01;
        trip = 6'b000_101;
        cyc(STARTUP + 2);

        // Short pulse must not assert
        brout_filt[0] = 1'b1;
        cyc(DEB_CNT - 1);
        brout_filt[0] = 1'b0;
        cyc(6);

        // Sustained high asserts, then short hold expires
        brout_filt[0] = 1'b1;
        cyc(DEB_CNT + 4);
        force_short_oneshot = 1'b1;
        brout_filt[0] = 1'b0;
        cyc(HOLD_SHORT + 4);

        // Long hold
        brout_filt[0] = 1'b1;
        cyc(DEB_CNT + 3);
        force_short_oneshot = 1'b0;
        brout_filt[0] = 1'b0;
        cyc(HOLD_LONG + 4);

        // Re-raise mid-hold, then a full-length short hold on release
        force_short_oneshot = 1'b1;
        brout_filt[0] = 1'b1;
        cyc(DEB_CNT + 3);
        brout_filt[0] = 1'b0;
        cyc(8);
        brout_filt[0] = 1'b1;
        cyc(4);
        brout_filt[0] = 1'b0;
        cyc(HOLD_SHORT + 4);

        // Drop ena while asserted
        brout_filt[0] = 1'b1;
        cyc(DEB_CNT + 3);
        ena[0] = 1'b0;
        cyc(2);
        clr[0] = 1'b1;
        cyc(1);
        clr[0] = 1'b0;

        // Re-enable with input high; clear plus trip change on the assert edge
        ena[0] = 1'b1;
        cyc(STARTUP + 1 + DEB_CNT);
        clr[0] = 1'b1;
        trip = 6'b011_010;
        cyc(1);
        clr[0] = 1'b0;
        cyc(3);

        // Asynchronous reset in the middle of a hold on ch0, ch1 active
        ena = 2'b11;
        brout_filt = 2'b01;
        cyc(DEB_CNT + 3);
        brout_filt[0] = 1'b0;
        cyc(6);
        #2;
        rst_n = 1'b0;
        model_reset();
        q.push_back(reset_exp());
        ->ev_async;
        cyc(2);
        rst_n = 1'b1;
        cyc(STARTUP + 5);

        // Random traffic
        force_short_oneshot = 1'b1;
        for (int n = 0; n < 2500; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(5) == 0)  brout_filt[c] = ~brout_filt[c];
                if ($urandom_range(60) == 0) ena[c] = ~ena[c];
                clr[c] = ($urandom_range(9) == 0);
            end
            if ($urandom_range(15) == 0) trip = (NCH*TRIP_W)'($urandom);
            if ($urandom_range(30) == 0) force_rc_osc = ~force_rc_osc;
            cyc(1);
        end

        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
